wb_b3_burst_master: RTL and testbench
=====================================

# wb_b3_burst_master

Wishbone B3 registered-feedback burst initiator: turns a simple command/data-stream request into one CTI/BTE-tagged Wishbone transaction. It is the master-side counterpart of the `wb_ram` burst responder. It plugs into the `wb_intercon` as an additional master, for DMA engines, memory testers and the boot loader. Incrementing (linear) and wrap-4/8/16 bursts are supported.

## Interface
Parameters:
- `AW`, 32, address width (byte address)
- `DW`, 32, data width; byte lanes = DW/8
- `LEN_W`, 8, burst length field width; beats = `cmd_len_i`+1 (1..2^LEN_W)

Ports:
- `wb_clk_i` in 1: the single clock.
- `wb_rst_i` in 1: synchronous, active-high reset.
- `cmd_valid_i` / `cmd_ready_o` in/out 1: command handshake.
- `cmd_adr_i` in AW: start byte address; word-aligned, low bits ignored.
- `cmd_we_i` in 1: 1 = write, 0 = read.
- `cmd_sel_i` in DW/8: byte select applied to every beat.
- `cmd_len_i` in LEN_W: beats − 1.
- `cmd_bte_i` in 2: 00 linear, 01 wrap4, 10 wrap8, 11 wrap16.
- `wdat_i` in DW, `wdat_valid_i` in 1, `wdat_ready_o` out 1: write-data stream.
- `rdat_o` out DW, `rdat_valid_o` out 1: read-data stream; no backpressure.
- `done_o` out 1: one-cycle pulse at the end of the transaction.
- `done_status_o` out 2: 00 ok, 01 err, 10 rty.
- `done_beats_o` out LEN_W+1: number of beats acked.
- `wb_adr_o`, `wb_dat_o`, `wb_sel_o`, `wb_we_o`, `wb_cyc_o`, `wb_stb_o`, `wb_cti_o`[2:0], `wb_bte_o`[1:0]: out, Wishbone master signals.
- `wb_dat_i`, `wb_ack_i`, `wb_err_i`, `wb_rty_i`: in, Wishbone slave responses.

## Operation
- FSM states: IDLE, BURST, DONE.
- IDLE
  - `cmd_ready_o`=1.
  - On `cmd_valid_i`: latch the command, clear the beat counter, go to BURST.
  - Drive `cyc`=1, `adr`=start, `we`, `sel`, `bte`.
  - Read commands raise `stb`=1 immediately.
- BURST, `wb_cti_o` rule:
  - 010 while remaining beats > 1.
  - 111 on the last beat.
  - A single-beat command gets 111 from the start.
  - `wb_bte_o` = latched bte; it is 00 for linear.
- Address generation on each ack:
  - Next address = adr + DW/8.
  - For wrap-N, only the low log2(N)+log2(DW/8) bits increment, modulo the N-beat aligned block. Upper bits are held.
  - Linear bursts wrap modulo 2^AW.
- Writes:
  - `wdat_ready_o` = BURST & we & beats_loaded < beats & (!stb | ack).
  - On a data handshake: `wb_dat_o`←`wdat_i`, `stb`←1.
  - On ack with no new data: `stb`←0 and `cyc` stays 1 (wait state). `cti`/`adr` must already reflect the next beat.
- Reads:
  - `stb` stays 1 for all beats.
  - Each ack registers `rdat_o`←`wb_dat_i` and `rdat_valid_o`←1 on the next cycle.
- Termination:
  - Final ack, or any `err`/`rty` → go to DONE. `cyc`, `stb` and `cti` drop on the same edge.
  - `err` or `rty` aborts the remaining beats. The errored beat is not counted and produces no `rdat_valid_o`.
  - If `err` and `rty` are asserted together, `err` wins.
  - `ack` together with `err` counts as `err`.
- DONE: `done_o`=1 for one cycle with status and beat count, then go to IDLE.

## Timing
- Reset values:
  - All outputs 0, state IDLE.
  - `cmd_ready_o` goes to 1 in the first cycle after reset.
  - `wb_cti_o`=000, `wb_bte_o`=00.
- Reset asserted mid-burst: `cyc`/`stb` are 0 on the next edge, with no `done_o`. Any pending read data is discarded.
- Command accepted at edge N: `cyc` is high from N+1.
  - Read: `stb` high from N+1.
  - Write: `stb` high on the edge after the first `wdat` handshake.
- Zero-wait-state slave:
  - Read of B beats: `cyc` is high for B cycles.
  - `rdat_valid_o` lags each ack by 1 cycle.
  - `done_o` is at N+B+1.
- `cmd_ready_o` is 0 from acceptance through DONE, so a new command is accepted in IDLE only. Minimum gap of one idle cycle between transactions.
- All Wishbone outputs are registered; there is no combinational path from `wb_ack_i` to `wb_*_o`.

## Structure
- Package `wb_b3_pkg` holds:
  - CTI constants: CLASSIC 000, INC 010, EOB 111.
  - BTE constants: LINEAR, WRAP4, WRAP8, WRAP16.
  - Status codes: OK, ERR, RTY.
- Sub-module `wb_b3_addr_gen`: combinational next-address function of (adr, bte, DW). It is shared with the burst responders.
- The top module holds the FSM, beat counters, data registers and the status register.

## Test plan
- Single read at 0x100, `cmd_len`=0, zero-wait RAM → one beat with `cti`=111, `bte`=00. `rdat` = RAM[0x100]. `done_o` status 00, beats 1.
- Wrap4 read at 0x108, len=3 → addresses 0x108, 0x10C, 0x100, 0x104. `cti` = 010, 010, 010, 111. `bte`=01.
- Linear write at 0x200, len=7, with `wdat_valid` deasserted for 3 cycles after beat 2 → `stb` low during the gap while `cyc` stays 1. RAM holds 8 correct words. Beats 8.
- Read burst len=15 with slave `err` on beat 5 → `cyc` drops the next edge. 5 `rdat_valid` pulses. Status 01, beats 5.
- `wb_rst_i` asserted at beat 3 of an 8-beat write → `cyc`/`stb` are 0 the next edge and no `done_o`. A following single-beat command completes normally.
- Simultaneous `err`+`rty` on beat 0 → status 01, beats 0.

Source files
------------

// File: rtl/wb_b3_pkg.sv
// Shared Wishbone B3 encodings for the burst master and the burst responders.
// Cycle-type, burst-type and completion-status codes plus a wrap-size helper.
package wb_b3_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INC     = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] BTE_LINEAR  = 2'b00;
  localparam logic [1:0] BTE_WRAP4   = 2'b01;
  localparam logic [1:0] BTE_WRAP8   = 2'b10;
  localparam logic [1:0] BTE_WRAP16  = 2'b11;

  localparam logic [1:0] STAT_OK     = 2'b00;
  localparam logic [1:0] STAT_ERR    = 2'b01;
  localparam logic [1:0] STAT_RTY    = 2'b10;

  // log2 of the beats in one wrap block; 0 means no wrapping (linear)
  function automatic int unsigned wrap_log2(input logic [1:0] bte);
    case (bte)
      BTE_WRAP4:  return 2;
      BTE_WRAP8:  return 3;
      BTE_WRAP16: return 4;
      default:    return 0;
    endcase
  endfunction

endpackage

// File: rtl/wb_b3_addr_gen.sv
// Next-beat byte address for a Wishbone B3 burst: linear increment or
// wrap-4/8/16 inside the aligned block, upper address bits held.
module wb_b3_addr_gen
  import wb_b3_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic [AW-1:0] adr,
  input  logic [1:0]    bte,
  output logic [AW-1:0] next_adr
);

  localparam int unsigned LANE_W = $clog2(DW / 8);

  logic [AW-1:0] mask;
  logic [AW-1:0] inc;

  always_comb begin
    if (bte == BTE_LINEAR) begin
      mask = '1;
    end else begin
      mask = AW'((64'd1 << (wrap_log2(bte) + LANE_W)) - 64'd1);
    end
    inc      = adr + AW'(DW / 8);
    next_adr = (adr & ~mask) | (inc & mask);
  end

endmodule

// File: rtl/wb_b3_burst_master.sv
// Wishbone B3 registered-feedback burst initiator: one command in, one
// CTI/BTE-tagged linear or wrapping burst out, with a done/status pulse.
module wb_b3_burst_master
  import wb_b3_pkg::*;
#(
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int LEN_W = 8
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [AW-1:0]     cmd_adr_i,
  input  logic              cmd_we_i,
  input  logic [DW/8-1:0]   cmd_sel_i,
  input  logic [LEN_W-1:0]  cmd_len_i,
  input  logic [1:0]        cmd_bte_i,
  input  logic [DW-1:0]     wdat_i,
  input  logic              wdat_valid_i,
  output logic              wdat_ready_o,
  output logic [DW-1:0]     rdat_o,
  output logic              rdat_valid_o,
  output logic              done_o,
  output logic [1:0]        done_status_o,
  output logic [LEN_W:0]    done_beats_o,
  output logic [AW-1:0]     wb_adr_o,
  output logic [DW-1:0]     wb_dat_o,
  output logic [DW/8-1:0]   wb_sel_o,
  output logic              wb_we_o,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  output logic [2:0]        wb_cti_o,
  output logic [1:0]        wb_bte_o,
  input  logic [DW-1:0]     wb_dat_i,
  input  logic              wb_ack_i,
  input  logic              wb_err_i,
  input  logic              wb_rty_i
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BURST = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [LEN_W:0] BEAT1 = (LEN_W + 1)'(1);
  localparam logic [LEN_W:0] BEAT2 = (LEN_W + 1)'(2);

  logic [1:0]     state;
  logic [LEN_W:0] beats;
  logic [LEN_W:0] acked;
  logic [LEN_W:0] loaded;
  logic [LEN_W:0] rem;
  logic [AW-1:0]  next_adr;
  logic           good_ack;
  logic           fault;
  logic           wr_hs;

  wb_b3_addr_gen #(
    .AW (AW),
    .DW (DW)
  ) u_addr_gen (
    .adr      (wb_adr_o),
    .bte      (wb_bte_o),
    .next_adr (next_adr)
  );

  // err outranks rty, and either outranks a coincident ack
  assign fault    = wb_stb_o & (wb_err_i | wb_rty_i);
  assign good_ack = wb_stb_o & wb_ack_i & ~wb_err_i & ~wb_rty_i;
  assign rem      = beats - acked;

  assign wdat_ready_o = (state == S_BURST) & wb_we_o & (loaded < beats) &
                        (~wb_stb_o | wb_ack_i);
  assign wr_hs        = wdat_ready_o & wdat_valid_i;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state         <= S_IDLE;
      cmd_ready_o   <= 1'b0;
      rdat_o        <= '0;
      rdat_valid_o  <= 1'b0;
      done_o        <= 1'b0;
      done_status_o <= STAT_OK;
      done_beats_o  <= '0;
      wb_adr_o      <= '0;
      wb_dat_o      <= '0;
      wb_sel_o      <= '0;
      wb_we_o       <= 1'b0;
      wb_cyc_o      <= 1'b0;
      wb_stb_o      <= 1'b0;
      wb_cti_o      <= CTI_CLASSIC;
      wb_bte_o      <= BTE_LINEAR;
      beats         <= '0;
      acked         <= '0;
      loaded        <= '0;
    end else begin
      done_o       <= 1'b0;
      rdat_valid_o <= 1'b0;
      case (state)
        S_IDLE: begin
          cmd_ready_o <= 1'b1;
          if (cmd_ready_o && cmd_valid_i) begin
            cmd_ready_o <= 1'b0;
            state       <= S_BURST;
            wb_cyc_o    <= 1'b1;
            wb_stb_o    <= ~cmd_we_i;
            wb_adr_o    <= cmd_adr_i & ~AW'(DW / 8 - 1);
            wb_we_o     <= cmd_we_i;
            wb_sel_o    <= cmd_sel_i;
            wb_bte_o    <= cmd_bte_i;
            wb_cti_o    <= (cmd_len_i == '0) ? CTI_EOB : CTI_INC;
            beats       <= {1'b0, cmd_len_i} + BEAT1;
            acked       <= '0;
            loaded      <= '0;
          end
        end

        S_BURST: begin
          if (fault) begin
            state         <= S_DONE;
            wb_cyc_o      <= 1'b0;
            wb_stb_o      <= 1'b0;
            wb_cti_o      <= CTI_CLASSIC;
            done_o        <= 1'b1;
            done_status_o <= wb_err_i ? STAT_ERR : STAT_RTY;
            done_beats_o  <= acked;
          end else begin
            if (wr_hs) begin
              wb_dat_o <= wdat_i;
              wb_stb_o <= 1'b1;
              loaded   <= loaded + BEAT1;
            end else if (good_ack && wb_we_o) begin
              wb_stb_o <= 1'b0;
            end

            // adr/cti move to the next beat on every ack so a write wait
            // state already presents the following beat's attributes
            if (good_ack) begin
              acked <= acked + BEAT1;
              if (!wb_we_o) begin
                rdat_o       <= wb_dat_i;
                rdat_valid_o <= 1'b1;
              end
              if (rem == BEAT1) begin
                state         <= S_DONE;
                wb_cyc_o      <= 1'b0;
                wb_stb_o      <= 1'b0;
                wb_cti_o      <= CTI_CLASSIC;
                done_o        <= 1'b1;
                done_status_o <= STAT_OK;
                done_beats_o  <= acked + BEAT1;
              end else begin
                wb_adr_o <= next_adr;
                wb_cti_o <= (rem == BEAT2) ? CTI_EOB : CTI_INC;
              end
            end
          end
        end

        S_DONE: begin
          state       <= S_IDLE;
          cmd_ready_o <= 1'b1;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_b3_burst_master.sv
// Randomised bench for wb_b3_burst_master: behavioural RAM slave with wait,
// err and rty injection, checked against a burst-level reference model.
module tb_wb_b3_burst_master;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LEN_W = 8;

  logic              wb_clk_i = 1'b0;
  logic              wb_rst_i;
  logic              cmd_valid_i;
  logic              cmd_ready_o;
  logic [AW-1:0]     cmd_adr_i;
  logic              cmd_we_i;
  logic [DW/8-1:0]   cmd_sel_i;
  logic [LEN_W-1:0]  cmd_len_i;
  logic [1:0]        cmd_bte_i;
  logic [DW-1:0]     wdat_i;
  logic              wdat_valid_i;
  logic              wdat_ready_o;
  logic [DW-1:0]     rdat_o;
  logic              rdat_valid_o;
  logic              done_o;
  logic [1:0]        done_status_o;
  logic [LEN_W:0]    done_beats_o;
  logic [AW-1:0]     wb_adr_o;
  logic [DW-1:0]     wb_dat_o;
  logic [DW/8-1:0]   wb_sel_o;
  logic              wb_we_o;
  logic              wb_cyc_o;
  logic              wb_stb_o;
  logic [2:0]        wb_cti_o;
  logic [1:0]        wb_bte_o;
  logic [DW-1:0]     wb_dat_i;
  logic              wb_ack_i;
  logic              wb_err_i;
  logic              wb_rty_i;

  wb_b3_burst_master #(.AW(AW), .DW(DW), .LEN_W(LEN_W)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_adr_i(cmd_adr_i),
    .cmd_we_i(cmd_we_i), .cmd_sel_i(cmd_sel_i), .cmd_len_i(cmd_len_i), .cmd_bte_i(cmd_bte_i),
    .wdat_i(wdat_i), .wdat_valid_i(wdat_valid_i), .wdat_ready_o(wdat_ready_o),
    .rdat_o(rdat_o), .rdat_valid_o(rdat_valid_o),
    .done_o(done_o), .done_status_o(done_status_o), .done_beats_o(done_beats_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // ---------------- slave RAM (bench-owned) ----------------
  logic [31:0] mem [1024];
  logic [31:0] ref_mem [1024];
  int  slv_beat = 0;
  int  err_at = -1;
  int  rty_at = -1;
  bit  err_with_ack = 0;
  int  rdy_prob = 100;
  logic slv_rdy = 1'b1;
  logic at_fault;

  assign at_fault = (slv_beat == err_at) || (slv_beat == rty_at);
  assign wb_err_i = wb_cyc_o & wb_stb_o & (slv_beat == err_at);
  assign wb_rty_i = wb_cyc_o & wb_stb_o & (slv_beat == rty_at);
  assign wb_ack_i = wb_cyc_o & wb_stb_o & (at_fault ? err_with_ack : slv_rdy);
  assign wb_dat_i = mem[wb_adr_o[11:2]];

  always @(posedge wb_clk_i) begin
    if (!wb_cyc_o || wb_rst_i) slv_beat <= 0;
    else if (wb_stb_o && wb_ack_i && !wb_err_i && !wb_rty_i) begin
      slv_beat <= slv_beat + 1;
      if (wb_we_o) mem[wb_adr_o[11:2]] <= merge(mem[wb_adr_o[11:2]], wb_dat_o, wb_sel_o);
    end
  end

  // ---------------- write-data feeder and slave readiness ----------------
  logic [31:0] wq[$];
  bit feed_on = 0;
  int feed_idx = 0;
  int vprob = 100;
  int gap_after = -1;
  int gap_len = 0;
  int gap_left = 0;
  bit gap_done = 0;

  always begin
    @(posedge wb_clk_i);
    #1;
    slv_rdy = ($urandom_range(99) < rdy_prob);
    if (feed_on && feed_idx < wq.size()) begin
      if (gap_left > 0) begin
        wdat_valid_i = 1'b0;
        gap_left--;
      end else if (feed_idx == gap_after && !gap_done) begin
        gap_done = 1;
        gap_left = gap_len - 1;
        wdat_valid_i = 1'b0;
      end else begin
        wdat_valid_i = ($urandom_range(99) < vprob);
      end
      wdat_i = wq[feed_idx];
    end else begin
      wdat_valid_i = 1'b0;
    end
    @(negedge wb_clk_i);
    if (wdat_valid_i && wdat_ready_o) feed_idx++;
  end

  // ---------------- monitor ----------------
  logic [31:0] m_adr[$];
  logic [2:0]  m_cti[$];
  logic [1:0]  m_bte[$];
  logic [31:0] m_rd[$];
  int cyc_cnt = 0;
  int gap_cnt = 0;
  int done_cnt = 0;
  logic [1:0] d_stat;
  logic [8:0] d_beats;

  always @(negedge wb_clk_i) begin
    if (wb_cyc_o) cyc_cnt++;
    if (wb_cyc_o && !wb_stb_o) gap_cnt++;
    if (wb_cyc_o && wb_stb_o && wb_ack_i && !wb_err_i && !wb_rty_i) begin
      m_adr.push_back(wb_adr_o);
      m_cti.push_back(wb_cti_o);
      m_bte.push_back(wb_bte_o);
    end
    if (rdat_valid_o) m_rd.push_back(rdat_o);
    if (done_o) begin
      done_cnt++;
      d_stat  = done_status_o;
      d_beats = done_beats_o;
    end
  end

  task automatic clear_mon();
    m_adr.delete(); m_cti.delete(); m_bte.delete(); m_rd.delete();
    cyc_cnt = 0; gap_cnt = 0; done_cnt = 0;
  endtask

  // expected byte address of beat i from the burst rules
  function automatic logic [31:0] beat_adr(input logic [31:0] adr, input logic [1:0] bte, input int i);
    logic [31:0] a0, base, blk;
    int nblk;
    a0 = adr & 32'hFFFF_FFFC;
    if (bte == 2'b00) return a0 + 32'(4 * i);
    nblk = 2 << bte;
    blk  = 32'(nblk * 4);
    base = a0 - (a0 % blk);
    return base + 32'((((a0 - base) / 4 + 32'(i)) % 32'(nblk)) * 4);
  endfunction

  task automatic issue_cmd(input logic [31:0] adr, input bit we, input logic [3:0] sel, input int len, input logic [1:0] bte);
    int lim = 0;
    while (!cmd_ready_o && lim < 100) begin @(negedge wb_clk_i); lim++; end
    check("cmd_ready", cmd_ready_o, 1);
    @(negedge wb_clk_i);
    cmd_valid_i = 1'b1; cmd_adr_i = adr; cmd_we_i = we; cmd_sel_i = sel;
    cmd_len_i = LEN_W'(len); cmd_bte_i = bte;
    @(posedge wb_clk_i);
    #1;
    cmd_valid_i = 1'b0;
  endtask

  task automatic run_txn(input logic [31:0] adr, input bit we, input logic [3:0] sel, input int len,
                         input logic [1:0] bte, input int e_at, input int r_at, input bit e_ack,
                         input int rprob, input int vp, input int g_after, input int g_len, input bit zero_wait);
    int B, fault, n_ok, lat;
    logic [1:0] es;
    logic [31:0] ea[$];
    logic first_cyc, first_stb;
    B = len + 1;
    for (int i = 0; i < B; i++) ea.push_back(beat_adr(adr, bte, i));
    fault = B;
    if (e_at >= 0 && e_at < fault) fault = e_at;
    if (r_at >= 0 && r_at < fault) fault = r_at;
    n_ok = fault;
    es = (fault == B) ? 2'b00 : (fault == e_at) ? 2'b01 : 2'b10;

    wq.delete();
    for (int i = 0; i < B; i++) wq.push_back($urandom);
    err_at = e_at; rty_at = r_at; err_with_ack = e_ack; rdy_prob = rprob;
    vprob = vp; gap_after = g_after; gap_len = g_len; gap_left = 0; gap_done = 0;
    @(posedge wb_clk_i);
    #1;
    clear_mon();
    feed_idx = 0;
    feed_on = we;
    issue_cmd(adr, we, sel, len, bte);

    lat = 0;
    first_cyc = 1'b0; first_stb = 1'b0;
    do begin
      @(negedge wb_clk_i);
      lat++;
      if (lat == 1) begin first_cyc = wb_cyc_o; first_stb = wb_stb_o; end
    end while (!done_o && lat < 4000);
    repeat (2) @(negedge wb_clk_i);
    #1;
    feed_on = 0;

    check("done_pulses", done_cnt, 1);
    check("first_cyc", first_cyc, 1);
    check("first_stb", first_stb, !we);
    check("status", d_stat, es);
    check("beats", d_beats, n_ok);
    check("ack_count", m_adr.size(), n_ok);
    for (int i = 0; i < n_ok && i < m_adr.size(); i++) begin
      check("adr", m_adr[i], ea[i]);
      check("cti", m_cti[i], (i == B - 1) ? 3'b111 : 3'b010);
      check("bte", m_bte[i], bte);
    end
    check("rdat_count", m_rd.size(), we ? 0 : n_ok);
    if (!we) begin
      for (int i = 0; i < n_ok && i < m_rd.size(); i++)
        check("rdat", m_rd[i], ref_mem[ea[i][11:2]]);
    end else begin
      for (int i = 0; i < n_ok; i++)
        ref_mem[ea[i][11:2]] = merge(ref_mem[ea[i][11:2]], wq[i], sel);
      for (int i = 0; i < B; i++)
        check("mem", mem[ea[i][11:2]], ref_mem[ea[i][11:2]]);
    end
    if (zero_wait) begin
      check("zw_cyc_len", cyc_cnt, B);
      check("zw_done_lat", lat, B + 1);
    end
    if (g_len > 0) check("stb_gap", gap_cnt >= g_len, 1);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] w;
    logic [31:0] a;
    int ln, ea_i, ra_i, lim;
    logic [1:0] bt;
    bit wr;

    for (int i = 0; i < 1024; i++) begin
      w = $urandom;
      mem[i] <= w;
      ref_mem[i] = w;
    end
    wb_rst_i = 1'b1;
    cmd_valid_i = 1'b0; cmd_adr_i = '0; cmd_we_i = 1'b0; cmd_sel_i = '0;
    cmd_len_i = '0; cmd_bte_i = '0; wdat_i = '0; wdat_valid_i = 1'b0;
    repeat (3) @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    check("rst_cyc", wb_cyc_o, 0);
    check("rst_stb", wb_stb_o, 0);
    check("rst_cti", wb_cti_o, 0);
    check("rst_bte", wb_bte_o, 0);
    check("rst_ready", cmd_ready_o, 0);
    check("rst_done", done_o, 0);
    check("rst_rvalid", rdat_valid_o, 0);
    check("rst_wready", wdat_ready_o, 0);
    wb_rst_i = 1'b0;
    @(negedge wb_clk_i);
    check("ready_after_rst", cmd_ready_o, 1);

    // single read, wrap4 read, gapped linear write, err abort, err+rty, linear 2^AW wrap
    run_txn(32'h100, 0, 4'hF, 0, 2'b00, -1, -1, 0, 100, 100, -1, 0, 1);
    run_txn(32'h108, 0, 4'hF, 3, 2'b01, -1, -1, 0, 100, 100, -1, 0, 1);
    check("wrap4_adr2", m_adr.size() > 2 ? m_adr[2] : 32'hDEAD, 32'h100);
    run_txn(32'h200, 1, 4'hF, 7, 2'b00, -1, -1, 0, 100, 100, 3, 3, 0);
    run_txn(32'h400, 0, 4'hF, 15, 2'b00, 5, -1, 0, 100, 100, -1, 0, 0);
    run_txn(32'h500, 0, 4'hF, 3, 2'b00, 0, 0, 1, 100, 100, -1, 0, 0);
    run_txn(32'hFFFF_FFF8, 0, 4'hF, 3, 2'b00, -1, -1, 0, 100, 100, -1, 0, 1);

    // reset in the middle of an 8-beat write
    wq.delete();
    for (int i = 0; i < 8; i++) wq.push_back($urandom);
    err_at = -1; rty_at = -1; rdy_prob = 100; vprob = 100; gap_after = -1; gap_len = 0; gap_done = 0;
    @(posedge wb_clk_i);
    #1;
    clear_mon();
    feed_idx = 0;
    feed_on = 1;
    issue_cmd(32'h300, 1, 4'hF, 7, 2'b00);
    lim = 0;
    while (slv_beat < 3 && lim < 200) begin @(negedge wb_clk_i); lim++; end
    check("rst_reach_beat3", slv_beat, 3);
    wb_rst_i = 1'b1;
    @(negedge wb_clk_i);
    check("midrst_cyc", wb_cyc_o, 0);
    check("midrst_stb", wb_stb_o, 0);
    check("midrst_done", done_o, 0);
    wb_rst_i = 1'b0;
    feed_on = 0;
    repeat (4) @(negedge wb_clk_i);
    #1;
    check("midrst_no_done", done_cnt, 0);
    for (int i = 0; i < 3; i++) ref_mem[(32'h300 >> 2) + i] = wq[i];
    for (int i = 0; i < 8; i++) check("midrst_mem", mem[(32'h300 >> 2) + i], ref_mem[(32'h300 >> 2) + i]);
    run_txn(32'h300, 0, 4'hF, 0, 2'b00, -1, -1, 0, 100, 100, -1, 0, 1);

    for (int t = 0; t < 40; t++) begin
      a  = $urandom & 32'h0000_0FFF;
      ln = $urandom_range(0, 20);
      bt = 2'($urandom_range(0, 3));
      wr = 1'($urandom_range(0, 1));
      ea_i = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, ln)) : -1;
      ra_i = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, ln)) : -1;
      run_txn(a, wr, wr ? 4'($urandom_range(1, 15)) : 4'hF, ln, bt, ea_i, ra_i,
              1'($urandom_range(0, 1)), $urandom_range(40, 100), $urandom_range(40, 100), -1, 0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
